// File: rtl/fifo_demux_pkg.sv
// Shared types and constants for the channel-interleaved FIFO read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_demux_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    // Encodings match the write-side selector so debug captures line up.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_demux_ch_demux.sv
// Decodes the word index into a one-hot shadow-register write enable.
// Latency: combinational.
// Backpressure: none; enable is qualified by the caller's FIFO read strobe.
module ch_demux
    import fifo_demux_pkg::*;
(
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_en,
    output logic [MAX_CH-1:0] o_we
);

    // One-hot select of the shadow slot for the word being consumed.
    always_comb begin
        o_we = '0;
        if (i_en) begin
            o_we[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_demux.sv
// De-interleaves one frame of (channels+1) words from an FWFT FIFO onto d0..d7.
// Latency: strobe at edge 0, words at edges 1..N, valid high after edge N+1.
// Backpressure: empty FIFO stalls the frame indefinitely; strobes while busy are dropped and counted.
module fifo_demux
    import fifo_demux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MISS_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_strobe,
    input  logic [2:0]        i_channels,
    input  logic              i_fifo_empty,
    input  logic [WIDTH-1:0]  i_fifo_dout,
    output logic              o_fifo_rd,
    input  logic              i_clear_err,
    output logic [WIDTH-1:0]  o_d0,
    output logic [WIDTH-1:0]  o_d1,
    output logic [WIDTH-1:0]  o_d2,
    output logic [WIDTH-1:0]  o_d3,
    output logic [WIDTH-1:0]  o_d4,
    output logic [WIDTH-1:0]  o_d5,
    output logic [WIDTH-1:0]  o_d6,
    output logic [WIDTH-1:0]  o_d7,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_missed,
    output logic [MISS_W-1:0] o_miss_cnt,
    output logic [7:0]        o_debug
);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_n_last;
    logic [WIDTH-1:0]    r_shadow [MAX_CH];
    logic [WIDTH-1:0]    r_d      [MAX_CH];
    logic                r_valid;
    logic                r_missed;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic                w_rd;
    logic                w_busy;
    logic                w_last;
    logic                w_start;
    logic                w_miss;
    logic [MAX_CH-1:0]   w_we;

    assign w_last  = w_rd && (r_idx == r_n_last);
    assign w_start = (r_state == ST_IDLE) && i_strobe;
    assign w_miss  = i_strobe && w_busy;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus read/busy decode; read is pure state-and-empty so a stalled frame never pops.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_strobe) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                w_busy = 1'b1;
                w_rd   = !i_fifo_empty;
                if (!i_fifo_empty && (r_idx == r_n_last)) begin
                    w_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_busy = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Word index and frame length; length latched at frame start so mid-frame changes are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx    <= '0;
            r_n_last <= '0;
        end else if (w_start) begin
            r_idx    <= '0;
            r_n_last <= i_channels;
        end else if (w_rd && (r_idx != r_n_last)) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    ch_demux u_ch_demux (
        .i_idx (r_idx),
        .i_en  (w_rd),
        .o_we  (w_we)
    );

    // Shadow capture of each consumed word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < MAX_CH; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_CH; k++) begin
                if (w_we[k]) begin
                    r_shadow[k] <= i_fifo_dout;
                end
            end
        end
    end

    // Frame commit: last word bypasses the shadow, unused channels are zeroed.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < MAX_CH; k++) begin
                r_d[k] <= '0;
            end
        end else if (w_last) begin
            for (int k = 0; k < MAX_CH; k++) begin
                if (3'(k) < r_n_last) begin
                    r_d[k] <= r_shadow[k];
                end else if (3'(k) == r_n_last) begin
                    r_d[k] <= i_fifo_dout;
                end else begin
                    r_d[k] <= '0;
                end
            end
        end
    end

    // Valid pulse for the cycle following the COMMIT state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_COMMIT);
        end
    end

    // Sticky miss flag and saturating counter; a miss on the clearing edge wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_missed   <= 1'b0;
            r_miss_cnt <= '0;
        end else if (w_miss) begin
            r_missed <= 1'b1;
            if (i_clear_err) begin
                r_miss_cnt <= MISS_W'(1);
            end else if (!(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + MISS_W'(1);
            end
        end else if (i_clear_err) begin
            r_missed   <= 1'b0;
            r_miss_cnt <= '0;
        end
    end

    assign o_fifo_rd  = w_rd;
    assign o_busy     = w_busy;
    assign o_valid    = r_valid;
    assign o_missed   = r_missed;
    assign o_miss_cnt = r_miss_cnt;
    assign o_debug    = {r_missed, r_state, r_idx, w_rd, r_valid};
    assign o_d0       = r_d[0];
    assign o_d1       = r_d[1];
    assign o_d2       = r_d[2];
    assign o_d3       = r_d[3];
    assign o_d4       = r_d[4];
    assign o_d5       = r_d[5];
    assign o_d6       = r_d[6];
    assign o_d7       = r_d[7];

endmodule

// File: tb/tb_fifo_demux.sv
// Directed bench for fifo_demux with a behavioural FWFT FIFO.
// Latency: n/a.
// Backpressure: FIFO model drives empty/head combinationally from its pointers.
module tb_fifo_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [2:0]  channels;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd;
    logic        clear_err;
    logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic        valid;
    logic        busy;
    logic        missed;
    logic [7:0]  miss_cnt;
    logic [7:0]  debug;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;

    always #5 clk = ~clk;

    fifo_demux #(.WIDTH(16), .MISS_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_strobe     (strobe),
        .i_channels   (channels),
        .i_fifo_empty (fifo_empty),
        .i_fifo_dout  (fifo_dout),
        .o_fifo_rd    (fifo_rd),
        .i_clear_err  (clear_err),
        .o_d0         (d0),
        .o_d1         (d1),
        .o_d2         (d2),
        .o_d3         (d3),
        .o_d4         (d4),
        .o_d5         (d5),
        .o_d6         (d6),
        .o_d7         (d7),
        .o_valid      (valid),
        .o_busy       (busy),
        .o_missed     (missed),
        .o_miss_cnt   (miss_cnt),
        .o_debug      (debug)
    );

    // FWFT FIFO model
    logic [15:0] fmem [64];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fmem[rd_ptr];
    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 6'd1;
    always @(posedge clk) if (valid) vcnt <= vcnt + 1;

    logic [15:0] dw [8];
    assign dw[0] = d0;
    assign dw[1] = d1;
    assign dw[2] = d2;
    assign dw[3] = d3;
    assign dw[4] = d4;
    assign dw[5] = d5;
    assign dw[6] = d6;
    assign dw[7] = d7;

    typedef struct {
        logic       strobe;
        logic [2:0] channels;
        logic       exp_rd;
        logic       exp_valid;
        logic       exp_busy;
    } vec_t;
    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_d(input string name, input logic [7:0][15:0] e);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s d%0d", name, k), {16'd0, dw[k]}, {16'd0, e[k]});
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({name, " valid seen"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; strobe = 1'b0; channels = 3'd0; clear_err = 1'b0;
        step(); step();
        // reset values
        check_d("reset", '0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset missed", {31'd0, missed}, 32'd0);
        chk("reset miss_cnt", {24'd0, miss_cnt}, 32'd0);
        chk("reset fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("reset debug", {24'd0, debug}, 32'd0);
        reset = 1'b0;
        step();

        // test 1: 4 channels, FIFO preloaded, cycle-accurate table
        for (int k = 1; k <= 4; k++) push(16'(k));
        tbl[0] = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            strobe   = tbl[i].strobe;
            channels = tbl[i].channels;
            step();
            chk($sformatf("t1 rd after edge %0d", i), {31'd0, fifo_rd}, {31'd0, tbl[i].exp_rd});
            chk($sformatf("t1 valid after edge %0d", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("t1 busy after edge %0d", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
        end
        check_d("t1", {16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h3, 16'h2, 16'h1});

        // test 2: 8 channels, FIFO starts empty, one word per 3 cycles
        channels = 3'd7; strobe = 1'b1;
        step();
        strobe = 1'b0;
        chk("t2 busy while empty", {31'd0, busy}, 32'd1);
        chk("t2 no read while empty", {31'd0, fifo_rd}, 32'd0);
        begin
            int v0;
            v0 = vcnt;
            for (int k = 0; k < 8; k++) begin
                push(16'(16'h100 + k));
                step(); step(); step();
                if (k < 7) begin
                    chk($sformatf("t2 idx held after word %0d", k), {29'd0, debug[4:2]}, 32'(k + 1));
                    chk($sformatf("t2 valid count mid-frame %0d", k), 32'(vcnt - v0), 32'd0);
                end
            end
            chk("t2 single valid", 32'(vcnt - v0), 32'd1);
        end
        check_d("t2", {16'h107, 16'h106, 16'h105, 16'h104, 16'h103, 16'h102, 16'h101, 16'h100});

        // test 3: strobes while busy, counter saturation, clear
        channels = 3'd3;
        push(16'h21); push(16'h22);
        strobe = 1'b1;
        step();
        repeat (301) step();
        strobe = 1'b0;
        chk("t3 missed", {31'd0, missed}, 32'd1);
        chk("t3 miss_cnt saturated", {24'd0, miss_cnt}, 32'd255);
        chk("t3 busy stalled", {31'd0, busy}, 32'd1);
        chk("t3 idx stalled", {29'd0, debug[4:2]}, 32'd2);
        push(16'h23); push(16'h24);
        wait_valid("t3");
        check_d("t3", {16'h0, 16'h0, 16'h0, 16'h0, 16'h24, 16'h23, 16'h22, 16'h21});
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t3 missed cleared", {31'd0, missed}, 32'd0);
        chk("t3 miss_cnt cleared", {24'd0, miss_cnt}, 32'd0);
        // clear and miss on the same edge
        strobe = 1'b1;
        step();
        clear_err = 1'b1;
        step();
        strobe = 1'b0; clear_err = 1'b0;
        chk("t3 clear+miss missed", {31'd0, missed}, 32'd1);
        chk("t3 clear+miss cnt", {24'd0, miss_cnt}, 32'd1);
        for (int k = 0; k < 4; k++) push(16'(16'h51 + k));
        wait_valid("t3b");
        check_d("t3b", {16'h0, 16'h0, 16'h0, 16'h0, 16'h54, 16'h53, 16'h52, 16'h51});
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;

        // test 4: channels changed mid-frame
        for (int k = 0; k < 5; k++) push(16'(16'h31 + k));
        channels = 3'd3; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        channels = 3'd0;
        wait_valid("t4");
        check_d("t4", {16'h0, 16'h0, 16'h0, 16'h0, 16'h34, 16'h33, 16'h32, 16'h31});
        step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        wait_valid("t4b");
        check_d("t4b", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h35});
        chk("t4b fifo drained", {31'd0, fifo_empty}, 32'd1);

        // test 5: reset mid-frame
        for (int k = 0; k < 5; k++) push(16'(16'h41 + k));
        step();
        channels = 3'd3; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("t5 async d0", {16'd0, d0}, 32'd0);
        chk("t5 async busy", {31'd0, busy}, 32'd0);
        chk("t5 async rd", {31'd0, fifo_rd}, 32'd0);
        chk("t5 async debug", {24'd0, debug}, 32'd0);
        step();
        reset = 1'b0;
        channels = 3'd0; strobe = 1'b1;
        step();
        strobe = 1'b0;
        wait_valid("t5");
        check_d("t5", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h42});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
